// File: rtl/vram_responder_if.sv
// Bus bundle between VRAM clients, the responder and the VRAM itself.
// Signal names carry the responder's point of view (_i into it, _o out of it).
interface vram_responder_if #(
  parameter int ADDR_W = 15,
  parameter int DATA_W = 32
);
  logic              rd0_strobe_i;
  logic [ADDR_W-1:0] rd0_addr_i;
  logic              rd0_ack_o;
  logic [DATA_W-1:0] rd0_data_o;
  logic              rd1_strobe_i;
  logic [ADDR_W-1:0] rd1_addr_i;
  logic              rd1_ack_o;
  logic [DATA_W-1:0] rd1_data_o;
  logic              wr_strobe_i;
  logic [ADDR_W-1:0] wr_addr_i;
  logic [DATA_W-1:0] wr_data_i;
  logic [3:0]        wr_be_i;
  logic              wr_ack_o;
  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [3:0]        mem_be_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic [DATA_W-1:0] mem_rdata_i;

  // Responder side
  modport slave (
    input  rd0_strobe_i, rd0_addr_i, rd1_strobe_i, rd1_addr_i,
    input  wr_strobe_i, wr_addr_i, wr_data_i, wr_be_i, mem_rdata_i,
    output rd0_ack_o, rd0_data_o, rd1_ack_o, rd1_data_o, wr_ack_o,
    output mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );

  // Client / memory side
  modport master (
    output rd0_strobe_i, rd0_addr_i, rd1_strobe_i, rd1_addr_i,
    output wr_strobe_i, wr_addr_i, wr_data_i, wr_be_i, mem_rdata_i,
    input  rd0_ack_o, rd0_data_o, rd1_ack_o, rd1_data_o, wr_ack_o,
    input  mem_addr_o, mem_we_o, mem_be_o, mem_wdata_o
  );
endinterface

// File: rtl/vram_responder.sv
// VRAM responder: two read ports and one write port onto a single-port
// synchronous VRAM. Port 0 has fixed priority; port 1 and the write port
// share a round-robin pointer. One transaction in flight at a time.
module vram_responder #(
  parameter int ADDR_W       = 15,
  parameter int DATA_W       = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  vram_responder_if.slave  bus
);

  localparam int CNT_W = (READ_LATENCY < 1) ? 1 : $clog2(READ_LATENCY + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD_WAIT,
    S_RD_ACK,
    S_WR,
    S_WR_ACK
  } state_e;

  typedef enum logic [1:0] {
    P_RD0,
    P_RD1,
    P_WR
  } port_e;

  state_e            state_q, state_d;
  port_e             port_q, port_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              rr_wr_q, rr_wr_d;   // 1: write port wins a tie with rd1
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [3:0]        mem_be_q, mem_be_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [DATA_W-1:0] rd0_data_q, rd0_data_d;
  logic [DATA_W-1:0] rd1_data_q, rd1_data_d;

  // Arbitration in IDLE, read latency countdown, data capture
  always_comb begin
    state_d     = state_q;
    port_d      = port_q;
    cnt_d       = cnt_q;
    rr_wr_d     = rr_wr_q;
    mem_addr_d  = mem_addr_q;
    mem_we_d    = 1'b0;
    mem_be_d    = mem_be_q;
    mem_wdata_d = mem_wdata_q;
    rd0_data_d  = rd0_data_q;
    rd1_data_d  = rd1_data_q;
    case (state_q)
      S_IDLE: begin
        if (bus.rd0_strobe_i) begin
          port_d     = P_RD0;
          mem_addr_d = bus.rd0_addr_i;
          cnt_d      = CNT_W'(READ_LATENCY);
          state_d    = S_RD_WAIT;
        end else if (bus.rd1_strobe_i && (!bus.wr_strobe_i || !rr_wr_q)) begin
          port_d     = P_RD1;
          mem_addr_d = bus.rd1_addr_i;
          cnt_d      = CNT_W'(READ_LATENCY);
          rr_wr_d    = 1'b1;
          state_d    = S_RD_WAIT;
        end else if (bus.wr_strobe_i) begin
          port_d      = P_WR;
          mem_addr_d  = bus.wr_addr_i;
          mem_be_d    = bus.wr_be_i;
          mem_wdata_d = bus.wr_data_i;
          mem_we_d    = 1'b1;
          rr_wr_d     = 1'b0;
          state_d     = S_WR;
        end
      end
      S_RD_WAIT: begin
        if (cnt_q == '0) begin
          if (port_q == P_RD0) rd0_data_d = bus.mem_rdata_i;
          else                 rd1_data_d = bus.mem_rdata_i;
          state_d = S_RD_ACK;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_RD_ACK: state_d = S_IDLE;
      S_WR:     state_d = S_WR_ACK;
      S_WR_ACK: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // State and datapath registers; async reset aborts any transaction
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      port_q      <= P_RD0;
      cnt_q       <= '0;
      rr_wr_q     <= 1'b0;
      mem_addr_q  <= '0;
      mem_we_q    <= 1'b0;
      mem_be_q    <= '0;
      mem_wdata_q <= '0;
      rd0_data_q  <= '0;
      rd1_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      port_q      <= port_d;
      cnt_q       <= cnt_d;
      rr_wr_q     <= rr_wr_d;
      mem_addr_q  <= mem_addr_d;
      mem_we_q    <= mem_we_d;
      mem_be_q    <= mem_be_d;
      mem_wdata_q <= mem_wdata_d;
      rd0_data_q  <= rd0_data_d;
      rd1_data_q  <= rd1_data_d;
    end
  end

  assign bus.rd0_ack_o   = (state_q == S_RD_ACK) && (port_q == P_RD0);
  assign bus.rd1_ack_o   = (state_q == S_RD_ACK) && (port_q == P_RD1);
  assign bus.wr_ack_o    = (state_q == S_WR_ACK);
  assign bus.rd0_data_o  = rd0_data_q;
  assign bus.rd1_data_o  = rd1_data_q;
  assign bus.mem_addr_o  = mem_addr_q;
  assign bus.mem_we_o    = mem_we_q;
  assign bus.mem_be_o    = mem_be_q;
  assign bus.mem_wdata_o = mem_wdata_q;

endmodule
